// File: rtl/as_gpio_port.sv
// as_gpio_port: memory-mapped GPIO port with per-pin direction, set/clear
// access, synchronized pin inputs and rising-edge interrupts.
`timescale 1ns/1ps
module as_gpio_port #(
  parameter int NR_GPIOS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [63:0]         wdata_i,
  output logic [63:0]         rdata_o,
  output logic                ack_o,
  inout  wire  [NR_GPIOS-1:0] gpio_io,
  output logic                cs_o,
  output logic                irq_o
);

  localparam logic [ADDR_W-1:0] A_OUT   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DIR   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IN    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SET   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IEN   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_ISTAT = ADDR_W'(6);

  logic [NR_GPIOS-1:0] r_out;
  logic [NR_GPIOS-1:0] r_dir;
  logic [NR_GPIOS-1:0] r_ien;
  logic [NR_GPIOS-1:0] r_istat;
  logic [NR_GPIOS-1:0] r_sync1;
  logic [NR_GPIOS-1:0] r_sync2;
  logic [NR_GPIOS-1:0] r_edge;
  logic [63:0]         r_rdata;
  logic                r_ack;
  logic                r_cs;
  logic                r_irq;

  logic [NR_GPIOS-1:0] w_wdata;
  logic [NR_GPIOS-1:0] w_out_next;
  logic [NR_GPIOS-1:0] w_rise;
  logic [NR_GPIOS-1:0] w_w1c;
  logic [NR_GPIOS-1:0] w_istat_next;
  logic [63:0]         w_rdata;
  logic                w_sel_out;
  logic                w_sel_dir;
  logic                w_sel_set;
  logic                w_sel_clr;
  logic                w_sel_ien;
  logic                w_sel_istat;
  logic                w_unused;

  assign w_wdata  = wdata_i[NR_GPIOS-1:0];
  // Upper write-data bits are architecturally ignored.
  assign w_unused = ^wdata_i;

  assign w_sel_out   = we_i && (addr_i == A_OUT);
  assign w_sel_dir   = we_i && (addr_i == A_DIR);
  assign w_sel_set   = we_i && (addr_i == A_SET);
  assign w_sel_clr   = we_i && (addr_i == A_CLR);
  assign w_sel_ien   = we_i && (addr_i == A_IEN);
  assign w_sel_istat = we_i && (addr_i == A_ISTAT);

  // Pins are driven straight from the registers so the new value is on the
  // wire in the same cycle cs_o is raised.
  for (genvar gi = 0; gi < NR_GPIOS; gi++) begin : g_pin
    assign gpio_io[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
  end

  always_comb begin
    w_out_next = r_out;
    if (w_sel_out) begin
      w_out_next = w_wdata;
    end else if (w_sel_set) begin
      w_out_next = r_out | w_wdata;
    end else if (w_sel_clr) begin
      w_out_next = r_out & ~w_wdata;
    end
  end

  // A fresh edge wins over a simultaneous write-1-clear of the same bit.
  assign w_rise       = r_sync2 & ~r_edge & ~r_dir;
  assign w_w1c        = w_sel_istat ? w_wdata : '0;
  assign w_istat_next = (r_istat & ~w_w1c) | w_rise;

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      A_OUT:   w_rdata = 64'(r_out);
      A_DIR:   w_rdata = 64'(r_dir);
      A_IN:    w_rdata = 64'(r_sync2);
      A_IEN:   w_rdata = 64'(r_ien);
      A_ISTAT: w_rdata = 64'(r_istat);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out <= '0;
      r_dir <= '0;
      r_ien <= '0;
    end else begin
      r_out <= w_out_next;
      if (w_sel_dir) begin
        r_dir <= w_wdata;
      end
      if (w_sel_ien) begin
        r_ien <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_edge  <= '0;
      r_istat <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync1 <= gpio_io;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      r_istat <= w_istat_next;
      r_irq   <= |(r_istat & r_ien);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_cs    <= 1'b0;
    end else begin
      r_ack <= we_i | re_i;
      r_cs  <= w_sel_out | w_sel_set | w_sel_clr;
      if (we_i && re_i) begin
        r_rdata <= '0;
      end else if (re_i) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign rdata_o = r_rdata;
  assign ack_o   = r_ack;
  assign cs_o    = r_cs;
  assign irq_o   = r_irq;

endmodule

// File: doc/as_gpio_port.md
AS_GPIO_PORT -- requirements
Module: as_gpio_port

Interface
REQ-001 The block SHALL have parameter NR_GPIOS, default 8, number of GPIO pins (1..64).
REQ-002 The block SHALL have parameter ADDR_W, default 3, register word-address width.
REQ-003 The block SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port we_i  input  1  bus write strobe, one cycle per access.
REQ-006 The block SHALL have port re_i  input  1  bus read strobe, one cycle per access.
REQ-007 The block SHALL have port addr_i  input  ADDR_W  register word address.
REQ-008 The block SHALL have port wdata_i  input  64  write data; bits above NR_GPIOS-1 ignored.
REQ-009 The block SHALL have port rdata_o  output  64  registered read data; zero-extended above NR_GPIOS-1.
REQ-010 The block SHALL have port ack_o  output  1  one-cycle access acknowledge.
REQ-011 The block SHALL have port gpio_io  inout  NR_GPIOS  tri-state pins.
REQ-012 The block SHALL have port cs_o  output  1  one-cycle strobe marking a new output value on gpio_io.
REQ-013 The block SHALL have port irq_o  output  1  level interrupt request.

Function
REQ-014 The register map SHALL be: 0 OUT (rw), 1 DIR (rw, 1=output), 2 IN (ro), 3 SET (wo, write-1-set OUT), 4 CLR (wo, write-1-clear OUT), 5 IEN (rw), 6 ISTAT (rw1c), 7 reserved (reads 0, writes ignored).
REQ-015 A write sampled at rising edge N SHALL update the addressed register at edge N; ack_o SHALL be high from edge N to edge N+1.
REQ-016 A read sampled at edge N SHALL load rdata_o at edge N with ack_o high N to N+1; rdata_o SHALL hold its value until the next read.
REQ-017 Simultaneous we_i and re_i SHALL perform the write only; rdata_o SHALL load 0; ack_o one cycle.
REQ-018 Each pin i SHALL be driven with OUT[i] when DIR[i]=1 and be high-impedance when DIR[i]=0.
REQ-019 cs_o SHALL be high from edge N to edge N+1 for every write at edge N to OUT, SET or CLR, even if the value is unchanged; writes to other registers SHALL NOT assert cs_o.
REQ-020 gpio_io SHALL already carry the updated value whenever cs_o is high (stable at the falling edge inside the strobe).
REQ-021 Back-to-back OUT writes at edges N and N+1 SHALL hold cs_o high for two cycles, each cycle showing that write's value.
REQ-022 Pin inputs SHALL pass through a two-flop synchronizer; IN SHALL return the synchronized value for all pins, including output pins.
REQ-023 A rising edge on synchronized input i with DIR[i]=0 SHALL set ISTAT[i]; pins with DIR[i]=1 SHALL NOT set ISTAT.
REQ-024 A write-1-clear of ISTAT[i] in the same cycle as a new edge on pin i SHALL leave ISTAT[i] set.
REQ-025 irq_o SHALL be registered: irq_o = OR(ISTAT & IEN) one cycle after the terms change.
REQ-026 Pin-to-ISTAT latency SHALL be 3 rising edges (2 sync + 1 edge detect).

Reset
REQ-027 While rst_i=0, asynchronously: OUT, DIR, IEN, ISTAT, synchronizer and edge flops = 0; rdata_o = 0; ack_o, cs_o, irq_o = 0; all pins high-impedance.
REQ-028 Reset asserted mid-access SHALL abort it with no ack_o or cs_o pulse after release; first access SHALL be accepted on the first rising edge after rst_i=1.

Verification
REQ-029 Reset, write DIR=0xFF, write OUT=0x01 -> cs_o one cycle, gpio_io=0x01 at that negedge; ack_o each write.
REQ-030 OUT=0x01, write SET=0x06, then CLR=0x02 -> gpio_io 0x07 then 0x05, one cs_o pulse per write.
REQ-031 DIR=0x0F, drive pins[7:4]=0xA externally -> IN reads 0xA0|OUT[3:0] after 2 cycles; pins 7:4 not driven by block.
REQ-032 DIR=0x00, IEN=0x01, pin0 0->1 -> ISTAT=0x01 after 3 edges, irq_o next cycle; write ISTAT=0x01 -> irq_o low one cycle later.
REQ-033 W1C of ISTAT[0] coincident with new pin0 edge -> ISTAT[0] stays 1, irq_o stays high.
REQ-034 Write DIR and OUT, assert rst_i=0 between clock edges -> all outputs 0 immediately, pins released, no cs_o after release.
